vga_timing_gen: RTL and testbench

- Parametrised VGA/raster timing generator; successor to the single-axis horizontal counter.
- Produces horizontal and vertical pixel counters, hsync/vsync with configurable polarity, video_on, and line/frame strobes.
- Advances only on a pixel clock-enable, so it runs from the system clock at any integer divide.
- Sits between the clock-enable divider and the pixel/framebuffer read logic.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/mod_counter.sv | 28 ++
 rtl/vga_timing_gen.sv | 91 +++++++++
 tb/tb_vga_timing_gen.sv | 134 +++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing presets and the line/frame total helper used by the
// timing generator.
package vga_timing_pkg;

  function automatic int unsigned calc_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // 640x480@60, 25.175 MHz pixel clock, 800x525 total
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;

  // 800x600@60, 40 MHz pixel clock, 1056x628 total, positive syncs
  localparam int unsigned SVGA800_H_ACTIVE = 800;
  localparam int unsigned SVGA800_H_FP     = 40;
  localparam int unsigned SVGA800_H_SYNC   = 128;
  localparam int unsigned SVGA800_H_BP     = 88;
  localparam int unsigned SVGA800_V_ACTIVE = 600;
  localparam int unsigned SVGA800_V_FP     = 1;
  localparam int unsigned SVGA800_V_SYNC   = 4;
  localparam int unsigned SVGA800_V_BP     = 23;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MAX counter with enable; wrap is a combinational strobe for the edge
// that returns the count to zero.
module mod_counter #(
  parameter int unsigned MAX = 800,
  parameter int unsigned W   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  if (MAX < 1 || MAX > (2 ** W)) begin : g_bad_max
    $error("mod_counter: MAX=%0d does not fit in W=%0d bits", MAX, W);
  end

  // reset suppresses the strobe so an aborted line/frame never signals
  assign wrap = en && !rst && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst)     count <= '0;
    else if (en) count <= wrap ? '0 : count + W'(1);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters advanced on pix_en, registered
// sync/video decode aligned with the counts, and line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             new_line,
  output logic             new_frame
);

  localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0) begin : g_bad_timing
    $error("vga_timing_gen: active and sync widths must be non-zero");
  end
  if (H_TOTAL > (2 ** CNT_W) || V_TOTAL > (2 ** CNT_W)) begin : g_bad_width
    $error("vga_timing_gen: CNT_W=%0d too narrow for %0dx%0d", CNT_W, H_TOTAL, V_TOTAL);
  end

  logic             h_wrap, v_wrap;
  logic [CNT_W-1:0] h_nxt, v_nxt;

  mod_counter #(.MAX(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (pix_en),
    .count (h_count),
    .wrap  (h_wrap)
  );

  // h_wrap already carries pix_en and !rst, so it is the vertical enable
  mod_counter #(.MAX(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap),
    .count (v_count),
    .wrap  (v_wrap)
  );

  assign new_line  = h_wrap;
  assign new_frame = v_wrap;

  // decode the counts the counters will hold after this edge, so the
  // registered sync/video bits line up with h_count/v_count
  always_comb begin
    h_nxt = h_wrap ? '0 : h_count + CNT_W'(1);
    v_nxt = v_count;
    if (v_wrap)      v_nxt = '0;
    else if (h_wrap) v_nxt = v_count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync    <= ~HS_POL;
      vsync    <= ~VS_POL;
      video_on <= 1'b0;
    end else if (pix_en) begin
      hsync    <= (h_nxt >= HS_START && h_nxt <= HS_LAST) ? HS_POL : ~HS_POL;
      vsync    <= (v_nxt >= VS_START && v_nxt <= VS_LAST) ? VS_POL : ~VS_POL;
      video_on <= (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 640x480 instance and a tiny positive-polarity
// instance share randomized pix_en/rst; expected outputs come from a
// position-index model (enabled cycles since reset, split by div/mod).
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       nl;
    logic       nf;
  } obs_t;

  logic clk = 1'b0;
  logic rst, pix_en;
  always #5 clk = ~clk;

  logic [9:0] a_h, a_v;
  logic       a_hs, a_vs, a_vo, a_nl, a_nf;
  logic [3:0] b_h, b_v;
  logic       b_hs, b_vs, b_vo, b_nl, b_nf;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .h_count(a_h), .v_count(a_v), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_vo), .new_line(a_nl), .new_frame(a_nf)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .h_count(b_h), .v_count(b_v), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_vo), .new_line(b_nl), .new_frame(b_nf)
  );

  obs_t q_a[$], q_b[$];
  int   checks = 0;
  int   errors = 0;

  // n = enabled pixel slots since reset; raster position is plain div/mod
  function automatic obs_t model(input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp,
                                 input logic hp, input logic vp, input int n, input bit in_rst,
                                 input logic r, input logic en);
    int   ht = ha + hfp + hsw + hbp;
    int   vt = va + vfp + vsw + vbp;
    int   h  = n % ht;
    int   v  = n / ht;
    obs_t o;
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.hs = (h >= ha + hfp && h < ha + hfp + hsw) ? hp : ~hp;
    o.vs = (v >= va + vfp && v < va + vfp + vsw) ? vp : ~vp;
    o.vo = !in_rst && h < ha && v < va;
    o.nl = !r && en && h == ht - 1;
    o.nf = o.nl && v == vt - 1;
    return o;
  endfunction

  always @(negedge clk) begin
    obs_t exp_o, act_o;
    if (q_a.size() > 0) begin
      exp_o = q_a.pop_front();
      act_o = '{a_h, a_v, a_hs, a_vs, a_vo, a_nl, a_nf};
      checks++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL dut_a @%0t got h=%0d v=%0d hs=%b vs=%b vo=%b nl=%b nf=%b want h=%0d v=%0d hs=%b vs=%b vo=%b nl=%b nf=%b",
                 $time, act_o.h, act_o.v, act_o.hs, act_o.vs, act_o.vo, act_o.nl, act_o.nf,
                 exp_o.h, exp_o.v, exp_o.hs, exp_o.vs, exp_o.vo, exp_o.nl, exp_o.nf);
      end
    end
    if (q_b.size() > 0) begin
      exp_o = q_b.pop_front();
      act_o = '{{6'd0, b_h}, {6'd0, b_v}, b_hs, b_vs, b_vo, b_nl, b_nf};
      checks++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL dut_b @%0t got h=%0d v=%0d hs=%b vs=%b vo=%b nl=%b nf=%b want h=%0d v=%0d hs=%b vs=%b vo=%b nl=%b nf=%b",
                 $time, act_o.h, act_o.v, act_o.hs, act_o.vs, act_o.vo, act_o.nl, act_o.nf,
                 exp_o.h, exp_o.v, exp_o.hs, exp_o.vs, exp_o.vo, exp_o.nl, exp_o.nf);
      end
    end
  end

  initial begin
    int n_a = 0;
    int n_b = 0;
    bit in_rst = 1'b1;
    rst    = 1'b1;
    pix_en = 1'b1;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      @(posedge clk);
      if (rst) begin
        n_a = 0; n_b = 0; in_rst = 1'b1;
      end else if (pix_en) begin
        n_a = (n_a + 1) % (800 * 525);
        n_b = (n_b + 1) % (8 * 6);
        in_rst = 1'b0;
      end
      #1;
      // phases: reset, free-run lines, 1/0 toggling, then random enable and rare resets
      if (cyc < 2) begin
        rst = 1'b1; pix_en = 1'b1;
      end else if (cyc < 4000) begin
        rst = 1'b0; pix_en = 1'b1;
      end else if (cyc < 8000) begin
        rst = 1'b0; pix_en = (cyc % 2 == 0);
      end else if (cyc == 30000 || cyc == 30001) begin
        rst = 1'b1; pix_en = 1'(cyc % 2);
      end else begin
        rst    = ($urandom_range(0, 4999) == 0);
        pix_en = ($urandom_range(0, 3) != 0);
      end
      q_a.push_back(model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, n_a, in_rst, rst, pix_en));
      q_b.push_back(model(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, n_b, in_rst, rst, pix_en));
    end
    @(negedge clk);
    #1;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
